// File: rtl/md_pkg.sv
// Shared types for the multiply/divide unit: op encodings, FSM states, op classes.
// Pure declarations: no latency, no backpressure.
// Consumers import md_pkg::* and decode ops through op_class().
package md_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_MUL,
        CLS_DIV,
        CLS_MTHI,
        CLS_MTLO
    } md_class_e;

    // Accumulate ops share the multiply latency, so they fold into CLS_MUL.
    function automatic md_class_e op_class(input logic [3:0] op);
        md_class_e cls;
        cls = CLS_NONE;
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: cls = CLS_MUL;
            OP_DIV, OP_DIVU:                                         cls = CLS_DIV;
            OP_MTHI:                                                 cls = CLS_MTHI;
            OP_MTLO:                                                 cls = CLS_MTLO;
            default:                                                 cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/md_latency_ctr.sv
// Down-counter timing the busy window: load sets the count, done flags the last cycle.
// Latency: done is combinational from the count, high while the count equals 1.
// No backpressure; clear has priority over load and returns the count to zero.
module md_latency_ctr #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          clear,
    output logic          done
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: result computed at acceptance, committed to hi/lo after a fixed latency.
// Latency: MUL_CYCLES or DIV_CYCLES busy cycles; MTHI/MTLO write on the accepting edge.
// Backpressure: start while busy is dropped; flush abandons the in-flight op without touching hi/lo.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MUL_LAT = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES);

    md_state_e          state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;

    logic               ctr_load;
    logic               ctr_clear;
    logic [CW-1:0]      ctr_load_val;
    logic               ctr_done;

    logic               sgn;
    md_class_e          cls;
    logic [2*WIDTH-1:0] a_ext, b_ext, product, hilo, result;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

    // Full-width datapath: operands are extended to 2*WIDTH so the product is never truncated.
    always_comb begin
        sgn     = op_is_signed(op);
        cls     = op_class(op);
        a_ext   = sgn ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
        b_ext   = sgn ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
        product = a_ext * b_ext;
        hilo    = {hi_q, lo_q};

        // Sign-magnitude divide; most-negative / -1 falls out as most-negative with zero remainder.
        a_neg = sgn && src_a[WIDTH-1];
        b_neg = sgn && src_b[WIDTH-1];
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;
        b_div = (b_mag == '0) ? WIDTH'(1) : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;
        if (src_b == '0) begin
            quo = '1;
            rem = src_a;
        end

        result = '0;
        case (op)
            OP_MULT, OP_MULTU: result = product;
            OP_MADD, OP_MADDU: result = hilo + product;
            OP_MSUB, OP_MSUBU: result = hilo - product;
            OP_DIV,  OP_DIVU:  result = {rem, quo};
            default:           result = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        pend_d       = pend_q;
        ctr_load     = 1'b0;
        ctr_clear    = 1'b0;
        ctr_load_val = MUL_LAT;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (cls)
                        CLS_MUL: begin
                            pend_d       = result;
                            ctr_load     = 1'b1;
                            ctr_load_val = MUL_LAT;
                            state_d      = ST_RUN;
                        end
                        CLS_DIV: begin
                            pend_d       = result;
                            ctr_load     = 1'b1;
                            ctr_load_val = DIV_LAT;
                            state_d      = ST_RUN;
                        end
                        CLS_MTHI: hi_d = src_a;
                        CLS_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Flush outranks completion, so a squash on the final cycle never commits.
                if (flush) begin
                    pend_d    = '0;
                    ctr_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (ctr_done) begin
                    {hi_d, lo_d} = pend_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    md_latency_ctr #(
        .CW (CW)
    ) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .clear    (ctr_clear),
        .done     (ctr_done)
    );

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected {hi,lo} pushed at issue, popped when busy falls.
module tb_md_unit;
    import md_pkg::*;

    localparam int W    = 32;
    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         flush;
    logic         busy;
    logic [W-1:0] hi, lo;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] hilo_m;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    md_unit #(
        .WIDTH      (W),
        .MUL_CYCLES (MULC),
        .DIV_CYCLES (DIVC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint      sp;
        logic [63:0] up;
        int          sa, sb, q, r;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        up = {32'b0, a} * {32'b0, b};
        case (o)
            OP_MULT:  return sp;
            OP_MULTU: return up;
            OP_MADD:  return hl + sp;
            OP_MADDU: return hl + up;
            OP_MSUB:  return hl - sp;
            OP_MSUBU: return hl - up;
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return hl;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] o);
        return (o == OP_DIV || o == OP_DIVU) ? DIVC : MULC;
    endfunction

    // Returns at the falling edge inside the first cycle after the accepting edge.
    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; op = OP_NOP; src_a = '0; src_b = '0;
    endtask

    task automatic finish_op(input string tag, input int lat, input int seen);
        int          n;
        int          guard;
        logic        held;
        logic [63:0] expv;
        n = seen - 1;
        guard = 0;
        held = 1'b1;
        while (busy === 1'b1 && guard < 200) begin
            if ({hi, lo} !== hilo_m) held = 1'b0;
            n++;
            guard++;
            @(negedge clk);
        end
        check({tag, "/busy_cycles"}, 64'(n), 64'(lat));
        check({tag, "/hold"}, {63'b0, held}, 64'd1);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'bx;
        check({tag, "/hilo"}, {hi, lo}, expv);
        hilo_m = expv;
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back(model(o, a, b, hilo_m));
        drive(o, a, b);
        finish_op(tag, lat_of(o), 1);
    endtask

    task automatic run_mt(input string tag, input logic [3:0] o, input logic [31:0] a);
        logic [63:0] expv;
        exp_q.push_back((o == OP_MTHI) ? {a, hilo_m[31:0]} : {hilo_m[63:32], a});
        drive(o, a, 32'hDEAD_BEEF);
        check({tag, "/busy"}, {63'b0, busy}, 64'd0);
        expv = exp_q.pop_front();
        check({tag, "/hilo"}, {hi, lo}, expv);
        hilo_m = expv;
    endtask

    task automatic check_idle_unchanged(input string tag);
        check({tag, "/busy"}, {63'b0, busy}, 64'd0);
        check({tag, "/hilo"}, {hi, lo}, hilo_m);
    endtask

    initial begin
        logic [3:0] rops [8];
        reset = 1'b0; start = 1'b0; op = OP_NOP; src_a = '0; src_b = '0; flush = 1'b0;
        hilo_m = '0;
        rops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};

        #12;
        check("reset/busy", {63'b0, busy}, 64'd0);
        check("reset/hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult_neg1x2", OP_MULT, 32'hFFFF_FFFF, 32'd2);
        run_op("multu_ffx2", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("div_5_0", OP_DIV, 32'd5, 32'd0);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
        run_op("divu_big_0", OP_DIVU, 32'h9000_0001, 32'd0);
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        run_mt("mtlo_0", OP_MTLO, 32'd0);
        run_mt("mthi_1234", OP_MTHI, 32'h1234);
        run_op("madd_3x4", OP_MADD, 32'd3, 32'd4);
        run_op("msub_1xd", OP_MSUB, 32'd1, 32'hD);
        check("msub_scenario", {hi, lo}, 64'h0000_1233_FFFF_FFFF);

        // Second start on busy cycle 2 must be dropped.
        exp_q.push_back(model(OP_MULT, 32'd7, 32'hFFFF_FFFD, hilo_m));
        drive(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        @(negedge clk);
        start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0; op = OP_NOP;
        finish_op("mult_ignore_div", MULC, 3);

        // Flush on busy cycle 3 of a divide.
        drive(OP_DIV, 32'd1000, 32'd9);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_idle_unchanged("flush_div");
        run_op("mult_after_flush", OP_MULT, 32'h0001_0000, 32'h0001_0000);

        // Flush on the final busy cycle: nothing commits.
        drive(OP_MULTU, 32'h55, 32'h66);
        repeat (MULC - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_idle_unchanged("flush_last");

        // Flush and start together in IDLE: flush wins.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; op = OP_NOP;
        check_idle_unchanged("flush_start");
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_MTHI; src_a = 32'hAAAA;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; op = OP_NOP;
        check_idle_unchanged("flush_mthi");

        drive(OP_NOP, 32'h1, 32'h2);
        check_idle_unchanged("nop");
        drive(4'hF, 32'h1, 32'h2);
        check_idle_unchanged("undef_op");

        for (int i = 0; i < 16; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra, rb;
            ro = rops[$urandom_range(0, 7)];
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i[1:0] == 2'd3) rb = rb >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d", i), ro, ra, rb);
        end

        // Asynchronous reset on busy cycle 2 clears outputs before the next edge.
        drive(OP_MULT, 32'd123, 32'd456);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst/busy", {63'b0, busy}, 64'd0);
        check("arst/hi", {32'b0, hi}, 64'd0);
        check("arst/lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        hilo_m = '0;
        exp_q.delete();
        run_op("madd_after_reset", OP_MADD, 32'd6, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width.
REQ-002 Parameter MUL_CYCLES, default 5, busy cycles for multiply-class ops (>=1).
REQ-003 Parameter DIV_CYCLES, default 10, busy cycles for divide-class ops (>=1).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request qualifying op/src_a/src_b.
REQ-007 op  input  4  operation: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO, NOP.
REQ-008 src_a  input  WIDTH  rs operand.
REQ-009 src_b  input  WIDTH  rt operand.
REQ-010 flush  input  1  abandon in-flight op (pipeline squash).
REQ-011 busy  output  1  operation in progress.
REQ-012 hi  output  WIDTH  HI register.
REQ-013 lo  output  WIDTH  LO register.

Function
REQ-014 States IDLE and RUN only; IDLE->RUN on start with a multiply-, divide- or accumulate-class op.
REQ-015 In IDLE, start samples operands; the 2*WIDTH result is computed from the sampled values and held in a pending register, not in hi/lo.
REQ-016 busy rises the cycle after the accepted start and stays high exactly MUL_CYCLES (multiply/accumulate) or DIV_CYCLES (divide) cycles.
REQ-017 On the edge ending the last busy cycle, pending result loads hi/lo, busy falls, state returns to IDLE.
REQ-018 hi/lo keep their old values throughout RUN.
REQ-019 MULT/MULTU: {hi,lo} = signed/unsigned src_a*src_b, full 2*WIDTH product.
REQ-020 MADD(U)/MSUB(U): {hi,lo} = {hi,lo} +/- product; the {hi,lo} used is the value at acceptance; 2*WIDTH arithmetic wraps modulo 2^(2*WIDTH).
REQ-021 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with the sign of src_a (DIV).
REQ-022 Divide by zero: lo = all ones, hi = src_a; busy timing unchanged.
REQ-023 DIV of most-negative value by -1: lo = most-negative value, hi = 0.
REQ-024 MTHI/MTLO with start in IDLE: write src_a into hi/lo on that edge; busy stays low.
REQ-025 start while busy is ignored; the in-flight result is not disturbed.
REQ-026 start with NOP or an undefined op code: no state change.
REQ-027 flush in RUN: return to IDLE next edge, busy low, discard pending result, hi/lo unchanged.
REQ-028 flush and start in the same IDLE cycle: flush wins; the op is not accepted.
REQ-029 flush on the final RUN cycle: no write to hi/lo.
REQ-030 The 2*WIDTH intermediate result is never truncated before the hi/lo split.

Reset
REQ-031 Asserting reset low forces IDLE, busy=0, hi=0, lo=0, counter=0, pending=0 immediately, whether or not the block is in RUN.
REQ-032 The first start after reset release is accepted normally.

Structure
REQ-033 Shared package md_pkg holds the op encodings enum and the state enum.
REQ-034 The latency counter is a sub-module md_latency_ctr with load value, done pulse and clear.
REQ-035 Counter width is derived from max(MUL_CYCLES, DIV_CYCLES).
REQ-036 The top-level module contains no memories and no latches.

Verification
REQ-037 Scenario: MULT 0xFFFFFFFF x 2 (WIDTH=32) -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU of the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-038 Scenario: DIV -7 / 2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 5 / 0 -> lo=0xFFFFFFFF, hi=5.
REQ-039 Scenario: MTHI 0x1234, then MADD 3*4 -> hi=0x1234, lo=0x0000000C; then MSUB 1*0xD -> {hi,lo}=0x00001233_FFFFFFFF.
REQ-040 Scenario: MULT accepted, second start DIV on busy cycle 2 -> DIV ignored; hi/lo take the MULT result at cycle 5.
REQ-041 Scenario: flush on busy cycle 3 of DIV -> busy low next cycle, hi/lo keep their pre-DIV values; a new MULT is then accepted.
REQ-042 Scenario: reset low on busy cycle 2 -> busy, hi and lo read 0 before the next clk edge.
